// File: rtl/csr_access_stage_pkg.sv
// csr_access_stage_pkg
//   Shared definitions for the CSR access stage: CSR op encodings and the
//   floating-point CSR addresses that are subject to the FPU hazard stall.
package csr_access_stage_pkg;

    typedef enum logic [1:0] {
        CSR_OP_RSV = 2'b00,
        CSR_OP_RW  = 2'b01,
        CSR_OP_RS  = 2'b10,
        CSR_OP_RC  = 2'b11
    } csr_op_e;

    localparam logic [11:0] CSR_FFLAGS = 12'h001;
    localparam logic [11:0] CSR_FRM    = 12'h002;
    localparam logic [11:0] CSR_FCSR   = 12'h003;

    function automatic logic is_fp_csr(input logic [11:0] addr);
        return (addr == CSR_FFLAGS) || (addr == CSR_FRM) || (addr == CSR_FCSR);
    endfunction

endpackage

// File: rtl/csr_access_stage_if.sv
// csr_access_stage_if
//   Bundles the issue request, CSR storage read/write ports, FPU activity
//   notifications and the commit response of the CSR access stage.
//   slave  : the CSR access stage itself
//   master : the surrounding core (issue, CSR storage, FPU, commit)
interface csr_access_stage_if #(
    parameter int NUM_WARPS   = 4,
    parameter int NUM_THREADS = 4,
    parameter int UUID_BITS   = 44
);
    localparam int NW_BITS = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1;

    logic                       req_valid;
    logic                       req_ready;
    logic [UUID_BITS-1:0]       req_uuid;
    logic [NW_BITS-1:0]         req_wid;
    logic [NUM_THREADS-1:0]     req_tmask;
    logic [31:0]                req_pc;
    logic [4:0]                 req_rd;
    logic                       req_wb;
    logic [1:0]                 req_op;
    logic [11:0]                req_addr;
    logic                       req_use_imm;
    logic [4:0]                 req_imm;
    logic [4:0]                 req_rs1;
    logic [31:0]                req_rs1_data;

    logic                       csr_read_enable;
    logic [UUID_BITS-1:0]       csr_read_uuid;
    logic [11:0]                csr_read_addr;
    logic [NW_BITS-1:0]         csr_read_wid;
    logic [31:0]                csr_read_data;

    logic                       csr_write_enable;
    logic [UUID_BITS-1:0]       csr_write_uuid;
    logic [11:0]                csr_write_addr;
    logic [NW_BITS-1:0]         csr_write_wid;
    logic [31:0]                csr_write_data;

    logic                       fpu_req_fire;
    logic [NW_BITS-1:0]         fpu_req_wid;
    logic                       fpu_rsp_fire;
    logic [NW_BITS-1:0]         fpu_rsp_wid;

    logic                       rsp_valid;
    logic                       rsp_ready;
    logic [UUID_BITS-1:0]       rsp_uuid;
    logic [NW_BITS-1:0]         rsp_wid;
    logic [NUM_THREADS-1:0]     rsp_tmask;
    logic [31:0]                rsp_pc;
    logic [4:0]                 rsp_rd;
    logic                       rsp_wb;
    logic [NUM_THREADS*32-1:0]  rsp_data;
    logic                       rsp_eop;

    modport slave (
        input  req_valid, req_uuid, req_wid, req_tmask, req_pc, req_rd, req_wb,
               req_op, req_addr, req_use_imm, req_imm, req_rs1, req_rs1_data,
        output req_ready,
        output csr_read_enable, csr_read_uuid, csr_read_addr, csr_read_wid,
        input  csr_read_data,
        output csr_write_enable, csr_write_uuid, csr_write_addr, csr_write_wid,
               csr_write_data,
        input  fpu_req_fire, fpu_req_wid, fpu_rsp_fire, fpu_rsp_wid,
        output rsp_valid, rsp_uuid, rsp_wid, rsp_tmask, rsp_pc, rsp_rd, rsp_wb,
               rsp_data, rsp_eop,
        input  rsp_ready
    );

    modport master (
        output req_valid, req_uuid, req_wid, req_tmask, req_pc, req_rd, req_wb,
               req_op, req_addr, req_use_imm, req_imm, req_rs1, req_rs1_data,
        input  req_ready,
        input  csr_read_enable, csr_read_uuid, csr_read_addr, csr_read_wid,
        output csr_read_data,
        input  csr_write_enable, csr_write_uuid, csr_write_addr, csr_write_wid,
               csr_write_data,
        output fpu_req_fire, fpu_req_wid, fpu_rsp_fire, fpu_rsp_wid,
        input  rsp_valid, rsp_uuid, rsp_wid, rsp_tmask, rsp_pc, rsp_rd, rsp_wb,
               rsp_data, rsp_eop,
        output rsp_ready
    );

endinterface

// File: rtl/csr_fpu_pending.sv
// csr_fpu_pending
//   Per-warp count of outstanding FPU operations, with a nonzero flag per warp.
//   clk, reset          : clock, synchronous active-high reset
//   inc_fire, inc_wid   : an FPU op was issued by warp inc_wid
//   dec_fire, dec_wid   : an FPU op of warp dec_wid completed
//   nonzero             : bit w set while warp w has ops outstanding
module csr_fpu_pending #(
    parameter int NUM_WARPS        = 4,
    parameter int FPU_PENDING_SIZE = 16,
    parameter int NW_BITS          = 2,
    parameter int PW               = 5
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 inc_fire,
    input  logic [NW_BITS-1:0]   inc_wid,
    input  logic                 dec_fire,
    input  logic [NW_BITS-1:0]   dec_wid,
    output logic [NUM_WARPS-1:0] nonzero
);
    logic [PW-1:0]        count [NUM_WARPS];
    logic [NUM_WARPS-1:0] inc_hit;
    logic [NUM_WARPS-1:0] dec_hit;

    always_comb begin
        inc_hit = '0;
        dec_hit = '0;
        nonzero = '0;
        for (int w = 0; w < NUM_WARPS; w++) begin
            inc_hit[w] = inc_fire && (inc_wid == NW_BITS'(w));
            dec_hit[w] = dec_fire && (dec_wid == NW_BITS'(w));
            nonzero[w] = (count[w] != '0);
        end
    end

    // An issue and a completion for the same warp in one cycle cancel out.
    always_ff @(posedge clk) begin
        for (int w = 0; w < NUM_WARPS; w++) begin
            if (reset) begin
                count[w] <= '0;
            end else if (inc_hit[w] && !dec_hit[w]) begin
                assert (count[w] != PW'(FPU_PENDING_SIZE))
                    else $error("csr_fpu_pending: warp %0d counter overflow", w);
                count[w] <= count[w] + 1'b1;
            end else if (dec_hit[w] && !inc_hit[w]) begin
                assert (count[w] != '0)
                    else $error("csr_fpu_pending: warp %0d counter underflow", w);
                count[w] <= count[w] - 1'b1;
            end
        end
    end

endmodule

// File: rtl/csr_access_stage.sv
// csr_access_stage
//   CSR front-end: accepts CSR instructions from issue, performs the
//   CSRRW/CSRRS/CSRRC read-modify-write against CSR storage in the accept
//   cycle, stalls FP CSR accesses while the warp has FPU ops in flight, and
//   registers the old CSR value (per active lane) toward commit.
//   clk, reset : clock, synchronous active-high reset
//   bus        : issue request, CSR read/write ports, FPU notifications,
//                commit response
module csr_access_stage
    import csr_access_stage_pkg::*;
#(
    parameter int CORE_ID          = 0,
    parameter int NUM_WARPS        = 4,
    parameter int NUM_THREADS      = 4,
    parameter int UUID_BITS        = 44,
    parameter int FPU_PENDING_SIZE = 16
) (
    input  logic           clk,
    input  logic           reset,
    csr_access_stage_if.slave bus
);
    localparam int NW_BITS = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1;
    localparam int PW      = $clog2(FPU_PENDING_SIZE + 1);

    logic [NUM_WARPS-1:0]      pending_nz;
    logic                      fp_stall;
    logic                      accept;
    logic                      src_zero;
    logic                      suppress;
    logic [31:0]               src;
    logic [31:0]               wdata;
    logic [NUM_THREADS*32-1:0] lane_data;
    csr_op_e                   op;

    logic                      rsp_valid_q;
    logic [UUID_BITS-1:0]      rsp_uuid_q;
    logic [NW_BITS-1:0]        rsp_wid_q;
    logic [NUM_THREADS-1:0]    rsp_tmask_q;
    logic [31:0]               rsp_pc_q;
    logic [4:0]                rsp_rd_q;
    logic                      rsp_wb_q;
    logic [NUM_THREADS*32-1:0] rsp_data_q;

    csr_fpu_pending #(
        .NUM_WARPS        (NUM_WARPS),
        .FPU_PENDING_SIZE (FPU_PENDING_SIZE),
        .NW_BITS          (NW_BITS),
        .PW               (PW)
    ) u_pending (
        .clk      (clk),
        .reset    (reset),
        .inc_fire (bus.fpu_req_fire),
        .inc_wid  (bus.fpu_req_wid),
        .dec_fire (bus.fpu_rsp_fire),
        .dec_wid  (bus.fpu_rsp_wid),
        .nonzero  (pending_nz)
    );

    assign op = csr_op_e'(bus.req_op);

    always_comb begin
        src      = bus.req_use_imm ? 32'(bus.req_imm) : bus.req_rs1_data;
        src_zero = bus.req_use_imm ? (bus.req_imm == 5'd0) : (bus.req_rs1 == 5'd0);
        wdata    = bus.csr_read_data | src;
        suppress = 1'b1;
        case (op)
            CSR_OP_RW: begin
                wdata    = src;
                suppress = 1'b0;
            end
            CSR_OP_RS: begin
                wdata    = bus.csr_read_data | src;
                suppress = src_zero;
            end
            CSR_OP_RC: begin
                wdata    = bus.csr_read_data & ~src;
                suppress = src_zero;
            end
            default: begin
                // Reserved op behaves as a set with no write.
                wdata    = bus.csr_read_data | src;
                suppress = 1'b1;
            end
        endcase
    end

    always_comb begin
        lane_data = '0;
        for (int i = 0; i < NUM_THREADS; i++) begin
            lane_data[i*32 +: 32] = bus.req_tmask[i] ? bus.csr_read_data : 32'h0;
        end
    end

    // The counter is sampled as registered, so an increment in the accept
    // cycle does not block and a decrement to zero unblocks one cycle later.
    assign fp_stall = is_fp_csr(bus.req_addr) && pending_nz[bus.req_wid];

    // Gating with reset keeps both CSR ports quiet in a reset cycle.
    assign bus.req_ready = !reset && !fp_stall && (!rsp_valid_q || bus.rsp_ready);
    assign accept        = bus.req_valid && bus.req_ready;

    assign bus.csr_read_enable  = accept;
    assign bus.csr_read_uuid    = bus.req_uuid;
    assign bus.csr_read_addr    = bus.req_addr;
    assign bus.csr_read_wid     = bus.req_wid;

    assign bus.csr_write_enable = accept && !suppress;
    assign bus.csr_write_uuid   = bus.req_uuid;
    assign bus.csr_write_addr   = bus.req_addr;
    assign bus.csr_write_wid    = bus.req_wid;
    assign bus.csr_write_data   = wdata;

    always_ff @(posedge clk) begin
        if (reset) begin
            rsp_valid_q <= 1'b0;
            rsp_uuid_q  <= '0;
            rsp_wid_q   <= '0;
            rsp_tmask_q <= '0;
            rsp_pc_q    <= '0;
            rsp_rd_q    <= '0;
            rsp_wb_q    <= 1'b0;
            rsp_data_q  <= '0;
        end else if (accept) begin
            rsp_valid_q <= 1'b1;
            rsp_uuid_q  <= bus.req_uuid;
            rsp_wid_q   <= bus.req_wid;
            rsp_tmask_q <= bus.req_tmask;
            rsp_pc_q    <= bus.req_pc;
            rsp_rd_q    <= bus.req_rd;
            rsp_wb_q    <= bus.req_wb;
            rsp_data_q  <= lane_data;
        end else if (bus.rsp_ready) begin
            rsp_valid_q <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && accept) begin
            assert (bus.req_op != 2'b00)
                else $error("csr_access_stage core %0d: reserved csr op", CORE_ID);
        end
    end

    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_uuid  = rsp_uuid_q;
    assign bus.rsp_wid   = rsp_wid_q;
    assign bus.rsp_tmask = rsp_tmask_q;
    assign bus.rsp_pc    = rsp_pc_q;
    assign bus.rsp_rd    = rsp_rd_q;
    assign bus.rsp_wb    = rsp_wb_q;
    assign bus.rsp_data  = rsp_data_q;
    assign bus.rsp_eop   = 1'b1;

endmodule

// File: tb/tb_csr_access_stage.sv
// tb_csr_access_stage
//   Directed bench for csr_access_stage with a behavioural CSR storage model.
module tb_csr_access_stage;
    import csr_access_stage_pkg::*;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    csr_access_stage_if #(.NUM_WARPS(4), .NUM_THREADS(4), .UUID_BITS(44)) bus ();

    csr_access_stage #(
        .CORE_ID(0), .NUM_WARPS(4), .NUM_THREADS(4), .UUID_BITS(44), .FPU_PENDING_SIZE(16)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_errors = 0;

    // CSR storage: combinational read, write lands at the accept edge.
    logic [31:0] csr_mem [0:4095];
    logic        pre_en = 1'b0;
    logic [11:0] pre_addr = '0;
    logic [31:0] pre_data = '0;
    int          write_count = 0;

    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 4096; i++) csr_mem[i] <= 32'h0;
        end else if (pre_en) begin
            csr_mem[pre_addr] <= pre_data;
        end else if (bus.csr_write_enable) begin
            csr_mem[bus.csr_write_addr] <= bus.csr_write_data;
        end
        if (bus.csr_write_enable) write_count <= write_count + 1;
    end
    assign bus.csr_read_data = csr_mem[bus.csr_read_addr];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic idle();
        bus.req_valid = 1'b0;
    endtask

    task automatic preload(input logic [11:0] a, input logic [31:0] d);
        idle();
        pre_en = 1'b1; pre_addr = a; pre_data = d;
        step();
        pre_en = 1'b0;
    endtask

    task automatic set_req(input logic [1:0] wid, input logic [1:0] op, input logic [11:0] addr,
                           input logic use_imm, input logic [4:0] imm, input logic [4:0] rs1,
                           input logic [31:0] d, input logic [3:0] tmask, input logic [43:0] uuid);
        bus.req_valid    = 1'b1;
        bus.req_wid      = wid;
        bus.req_op       = op;
        bus.req_addr     = addr;
        bus.req_use_imm  = use_imm;
        bus.req_imm      = imm;
        bus.req_rs1      = rs1;
        bus.req_rs1_data = d;
        bus.req_tmask    = tmask;
        bus.req_uuid     = uuid;
        bus.req_pc       = 32'h0000_1000 + 32'(uuid[7:0]);
        bus.req_rd       = 5'd7;
        bus.req_wb       = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus.rsp_ready = 1'b1;
        set_req(2'd0, CSR_OP_RW, 12'h340, 1'b0, 5'd0, 5'd3, 32'h55, 4'hF, 44'd1);
        step(); step(); settle();
        n_checks++; if (bus.rsp_valid !== 1'b0) begin n_errors++; $display("FAIL reset_rsp_valid got %b exp 0", bus.rsp_valid); end
        n_checks++; if (bus.rsp_data !== 128'h0) begin n_errors++; $display("FAIL reset_rsp_data got %h exp 0", bus.rsp_data); end
        n_checks++; if (bus.rsp_uuid !== 44'h0) begin n_errors++; $display("FAIL reset_rsp_uuid got %h exp 0", bus.rsp_uuid); end
        n_checks++; if (bus.csr_write_enable !== 1'b0) begin n_errors++; $display("FAIL reset_wr_en got %b exp 0", bus.csr_write_enable); end
        n_checks++; if (bus.csr_read_enable !== 1'b0) begin n_errors++; $display("FAIL reset_rd_en got %b exp 0", bus.csr_read_enable); end
        reset = 1'b0;
        idle();
        step(); settle();
        n_checks++; if (bus.rsp_eop !== 1'b1) begin n_errors++; $display("FAIL rsp_eop got %b exp 1", bus.rsp_eop); end
        n_checks++; if (bus.rsp_valid !== 1'b0) begin n_errors++; $display("FAIL idle_rsp_valid got %b exp 0", bus.rsp_valid); end
    endtask

    task automatic test_rw();
        preload(12'h340, 32'h0);
        set_req(2'd0, CSR_OP_RW, 12'h340, 1'b0, 5'd0, 5'd3, 32'h1234, 4'hF, 44'd10);
        settle();
        n_checks++; if (bus.req_ready !== 1'b1) begin n_errors++; $display("FAIL rw_ready got %b exp 1", bus.req_ready); end
        n_checks++; if (bus.csr_read_enable !== 1'b1) begin n_errors++; $display("FAIL rw_rd_en got %b exp 1", bus.csr_read_enable); end
        n_checks++; if (bus.csr_write_enable !== 1'b1) begin n_errors++; $display("FAIL rw_wr_en got %b exp 1", bus.csr_write_enable); end
        n_checks++; if (bus.csr_write_addr !== 12'h340) begin n_errors++; $display("FAIL rw_wr_addr got %h exp 340", bus.csr_write_addr); end
        n_checks++; if (bus.csr_write_data !== 32'h1234) begin n_errors++; $display("FAIL rw_wr_data got %h exp 1234", bus.csr_write_data); end
        step();
        set_req(2'd0, CSR_OP_RS, 12'h340, 1'b0, 5'd0, 5'd0, 32'hFFFF, 4'hF, 44'd11);
        settle();
        n_checks++; if (bus.rsp_valid !== 1'b1) begin n_errors++; $display("FAIL rw_rsp_valid got %b exp 1", bus.rsp_valid); end
        n_checks++; if (bus.rsp_data !== 128'h0) begin n_errors++; $display("FAIL rw_rsp_data got %h exp 0", bus.rsp_data); end
        n_checks++; if (bus.rsp_uuid !== 44'd10) begin n_errors++; $display("FAIL rw_rsp_uuid got %0d exp 10", bus.rsp_uuid); end
        n_checks++; if (bus.rsp_pc !== 32'h100A) begin n_errors++; $display("FAIL rw_rsp_pc got %h exp 100a", bus.rsp_pc); end
        n_checks++; if (bus.csr_write_enable !== 1'b0) begin n_errors++; $display("FAIL rs0_wr_en got %b exp 0", bus.csr_write_enable); end
        n_checks++; if (bus.req_ready !== 1'b1) begin n_errors++; $display("FAIL b2b_ready got %b exp 1", bus.req_ready); end
        step(); idle(); settle();
        n_checks++; if (bus.rsp_data !== {4{32'h1234}}) begin n_errors++; $display("FAIL rs0_rsp_data got %h exp 4x1234", bus.rsp_data); end
        n_checks++; if (bus.rsp_uuid !== 44'd11) begin n_errors++; $display("FAIL rs0_rsp_uuid got %0d exp 11", bus.rsp_uuid); end
        step();
    endtask

    task automatic test_rs_rc();
        preload(12'h300, 32'hF0);
        set_req(2'd1, CSR_OP_RS, 12'h300, 1'b1, 5'd5, 5'd0, 32'h0, 4'hF, 44'd20);
        settle();
        n_checks++; if (bus.csr_write_enable !== 1'b1) begin n_errors++; $display("FAIL rs_wr_en got %b exp 1", bus.csr_write_enable); end
        n_checks++; if (bus.csr_write_data !== 32'hF5) begin n_errors++; $display("FAIL rs_wr_data got %h exp f5", bus.csr_write_data); end
        step(); idle(); settle();
        n_checks++; if (bus.rsp_data !== {4{32'hF0}}) begin n_errors++; $display("FAIL rs_rsp_data got %h exp 4xf0", bus.rsp_data); end
        preload(12'h301, 32'hFF);
        set_req(2'd1, CSR_OP_RC, 12'h301, 1'b0, 5'd0, 5'd2, 32'h0F, 4'hF, 44'd21);
        settle();
        n_checks++; if (bus.csr_write_enable !== 1'b1) begin n_errors++; $display("FAIL rc_wr_en got %b exp 1", bus.csr_write_enable); end
        n_checks++; if (bus.csr_write_data !== 32'hF0) begin n_errors++; $display("FAIL rc_wr_data got %h exp f0", bus.csr_write_data); end
        step(); idle(); settle();
        n_checks++; if (bus.rsp_data !== {4{32'hFF}}) begin n_errors++; $display("FAIL rc_rsp_data got %h exp 4xff", bus.rsp_data); end
        step();
    endtask

    task automatic test_tmask();
        preload(12'h340, 32'hAB);
        set_req(2'd0, CSR_OP_RS, 12'h340, 1'b0, 5'd0, 5'd0, 32'h0, 4'b0101, 44'd30);
        settle();
        n_checks++; if (bus.csr_write_enable !== 1'b0) begin n_errors++; $display("FAIL tmask_wr_en got %b exp 0", bus.csr_write_enable); end
        step(); idle(); settle();
        n_checks++; if (bus.rsp_data !== {32'h0, 32'hAB, 32'h0, 32'hAB}) begin n_errors++; $display("FAIL tmask_rsp_data got %h exp 0/ab/0/ab", bus.rsp_data); end
        n_checks++; if (bus.rsp_tmask !== 4'b0101) begin n_errors++; $display("FAIL tmask_rsp_tmask got %b exp 0101", bus.rsp_tmask); end
        step();
    endtask

    task automatic test_fp_hazard();
        idle();
        bus.fpu_req_fire = 1'b1; bus.fpu_req_wid = 2'd1;
        step(); step();
        bus.fpu_req_fire = 1'b0;
        set_req(2'd0, CSR_OP_RS, 12'h002, 1'b0, 5'd0, 5'd0, 32'h0, 4'hF, 44'd40);
        settle();
        n_checks++; if (bus.req_ready !== 1'b1) begin n_errors++; $display("FAIL fp_w0_ready got %b exp 1", bus.req_ready); end
        set_req(2'd1, CSR_OP_RS, 12'h340, 1'b0, 5'd0, 5'd0, 32'h0, 4'hF, 44'd40);
        #1;
        n_checks++; if (bus.req_ready !== 1'b1) begin n_errors++; $display("FAIL fp_nonfp_ready got %b exp 1", bus.req_ready); end
        set_req(2'd1, CSR_OP_RS, 12'h002, 1'b0, 5'd0, 5'd0, 32'h0, 4'hF, 44'd41);
        #1;
        n_checks++; if (bus.req_ready !== 1'b0) begin n_errors++; $display("FAIL fp_stall_ready got %b exp 0", bus.req_ready); end
        n_checks++; if (bus.csr_read_enable !== 1'b0) begin n_errors++; $display("FAIL fp_stall_rd_en got %b exp 0", bus.csr_read_enable); end
        bus.fpu_rsp_fire = 1'b1; bus.fpu_rsp_wid = 2'd1;
        step(); settle();
        n_checks++; if (bus.req_ready !== 1'b0) begin n_errors++; $display("FAIL fp_one_left_ready got %b exp 0", bus.req_ready); end
        step();
        bus.fpu_rsp_fire = 1'b0;
        settle();
        n_checks++; if (bus.req_ready !== 1'b1) begin n_errors++; $display("FAIL fp_release_ready got %b exp 1", bus.req_ready); end
        n_checks++; if (bus.csr_read_enable !== 1'b1) begin n_errors++; $display("FAIL fp_release_rd_en got %b exp 1", bus.csr_read_enable); end
        step(); idle(); settle();
        n_checks++; if (bus.rsp_uuid !== 44'd41) begin n_errors++; $display("FAIL fp_rsp_uuid got %0d exp 41", bus.rsp_uuid); end
        set_req(2'd3, CSR_OP_RS, 12'h003, 1'b0, 5'd0, 5'd0, 32'h0, 4'hF, 44'd42);
        bus.fpu_req_fire = 1'b1; bus.fpu_req_wid = 2'd3;
        settle();
        n_checks++; if (bus.req_ready !== 1'b1) begin n_errors++; $display("FAIL inc_vs_accept_ready got %b exp 1", bus.req_ready); end
        step();
        bus.fpu_req_fire = 1'b0;
        set_req(2'd3, CSR_OP_RS, 12'h003, 1'b0, 5'd0, 5'd0, 32'h0, 4'hF, 44'd43);
        settle();
        n_checks++; if (bus.req_ready !== 1'b0) begin n_errors++; $display("FAIL inc_then_stall_ready got %b exp 0", bus.req_ready); end
        n_checks++; if (bus.rsp_uuid !== 44'd42) begin n_errors++; $display("FAIL inc_rsp_uuid got %0d exp 42", bus.rsp_uuid); end
        bus.fpu_rsp_fire = 1'b1; bus.fpu_rsp_wid = 2'd3;
        step();
        bus.fpu_rsp_fire = 1'b0;
        settle();
        n_checks++; if (bus.req_ready !== 1'b1) begin n_errors++; $display("FAIL w3_release_ready got %b exp 1", bus.req_ready); end
        step(); idle(); settle();
        n_checks++; if (bus.rsp_uuid !== 44'd43) begin n_errors++; $display("FAIL w3_rsp_uuid got %0d exp 43", bus.rsp_uuid); end
        step();
    endtask

    task automatic test_back_to_back();
        int wc0;
        idle(); bus.rsp_ready = 1'b1; step();
        bus.rsp_ready = 1'b0;
        preload(12'h342, 32'h10);
        wc0 = write_count;
        set_req(2'd2, CSR_OP_RW, 12'h342, 1'b1, 5'd7, 5'd0, 32'h0, 4'hF, 44'd50);
        settle();
        n_checks++; if (bus.req_ready !== 1'b1) begin n_errors++; $display("FAIL bp_first_ready got %b exp 1", bus.req_ready); end
        step();
        set_req(2'd2, CSR_OP_RW, 12'h342, 1'b1, 5'd9, 5'd0, 32'h0, 4'hF, 44'd51);
        settle();
        for (int i = 0; i < 3; i++) begin
            n_checks++; if (bus.req_ready !== 1'b0) begin n_errors++; $display("FAIL bp_hold_ready[%0d] got %b exp 0", i, bus.req_ready); end
            n_checks++; if (bus.csr_write_enable !== 1'b0) begin n_errors++; $display("FAIL bp_hold_wr_en[%0d] got %b exp 0", i, bus.csr_write_enable); end
            n_checks++; if (bus.rsp_valid !== 1'b1) begin n_errors++; $display("FAIL bp_hold_valid[%0d] got %b exp 1", i, bus.rsp_valid); end
            n_checks++; if (bus.rsp_uuid !== 44'd50) begin n_errors++; $display("FAIL bp_hold_uuid[%0d] got %0d exp 50", i, bus.rsp_uuid); end
            n_checks++; if (bus.rsp_data !== {4{32'h10}}) begin n_errors++; $display("FAIL bp_hold_data[%0d] got %h exp 4x10", i, bus.rsp_data); end
            step(); settle();
        end
        n_checks++; if (write_count - wc0 !== 1) begin n_errors++; $display("FAIL bp_single_write got %0d exp 1", write_count - wc0); end
        bus.rsp_ready = 1'b1;
        #1;
        n_checks++; if (bus.req_ready !== 1'b1) begin n_errors++; $display("FAIL bp_release_ready got %b exp 1", bus.req_ready); end
        n_checks++; if (bus.csr_write_data !== 32'h9) begin n_errors++; $display("FAIL bp_b_wr_data got %h exp 9", bus.csr_write_data); end
        step();
        set_req(2'd2, CSR_OP_RW, 12'h342, 1'b1, 5'd11, 5'd0, 32'h0, 4'hF, 44'd52);
        settle();
        n_checks++; if (bus.rsp_uuid !== 44'd51) begin n_errors++; $display("FAIL bp_b_uuid got %0d exp 51", bus.rsp_uuid); end
        n_checks++; if (bus.rsp_data !== {4{32'h7}}) begin n_errors++; $display("FAIL bp_b_data got %h exp 4x7", bus.rsp_data); end
        n_checks++; if (bus.req_ready !== 1'b1) begin n_errors++; $display("FAIL bp_c_ready got %b exp 1", bus.req_ready); end
        n_checks++; if (bus.csr_write_data !== 32'hB) begin n_errors++; $display("FAIL bp_c_wr_data got %h exp b", bus.csr_write_data); end
        step(); idle(); settle();
        n_checks++; if (bus.rsp_uuid !== 44'd52) begin n_errors++; $display("FAIL bp_c_uuid got %0d exp 52", bus.rsp_uuid); end
        n_checks++; if (bus.rsp_data !== {4{32'h9}}) begin n_errors++; $display("FAIL bp_c_data got %h exp 4x9", bus.rsp_data); end
        n_checks++; if (write_count - wc0 !== 3) begin n_errors++; $display("FAIL bp_total_writes got %0d exp 3", write_count - wc0); end
        step();
    endtask

    task automatic test_reset_midop();
        idle();
        bus.fpu_req_fire = 1'b1; bus.fpu_req_wid = 2'd2;
        step(); step(); step();
        bus.fpu_req_fire = 1'b0;
        bus.rsp_ready = 1'b0;
        set_req(2'd0, CSR_OP_RW, 12'h340, 1'b0, 5'd0, 5'd1, 32'h77, 4'hF, 44'd60);
        step();
        set_req(2'd0, CSR_OP_RW, 12'h340, 1'b0, 5'd0, 5'd1, 32'h88, 4'hF, 44'd61);
        bus.rsp_ready = 1'b1;
        reset = 1'b1;
        settle();
        n_checks++; if (bus.rsp_valid !== 1'b1) begin n_errors++; $display("FAIL midop_pre_valid got %b exp 1", bus.rsp_valid); end
        n_checks++; if (bus.csr_write_enable !== 1'b0) begin n_errors++; $display("FAIL midop_reset_wr_en got %b exp 0", bus.csr_write_enable); end
        n_checks++; if (bus.csr_read_enable !== 1'b0) begin n_errors++; $display("FAIL midop_reset_rd_en got %b exp 0", bus.csr_read_enable); end
        step();
        reset = 1'b0;
        set_req(2'd2, CSR_OP_RS, 12'h003, 1'b0, 5'd0, 5'd0, 32'h0, 4'hF, 44'd62);
        settle();
        n_checks++; if (bus.rsp_valid !== 1'b0) begin n_errors++; $display("FAIL midop_rsp_dropped got %b exp 0", bus.rsp_valid); end
        n_checks++; if (bus.req_ready !== 1'b1) begin n_errors++; $display("FAIL midop_w2_ready got %b exp 1", bus.req_ready); end
        n_checks++; if (bus.csr_read_enable !== 1'b1) begin n_errors++; $display("FAIL midop_w2_rd_en got %b exp 1", bus.csr_read_enable); end
        step(); idle(); settle();
        n_checks++; if (bus.rsp_uuid !== 44'd62) begin n_errors++; $display("FAIL midop_w2_uuid got %0d exp 62", bus.rsp_uuid); end
        step();
    endtask

    initial begin
        reset = 1'b1;
        bus.req_valid = 1'b0;
        bus.rsp_ready = 1'b1;
        bus.fpu_req_fire = 1'b0; bus.fpu_req_wid = '0;
        bus.fpu_rsp_fire = 1'b0; bus.fpu_rsp_wid = '0;
        set_req(2'd0, CSR_OP_RW, 12'h0, 1'b0, 5'd0, 5'd0, 32'h0, 4'h0, 44'd0);
        test_reset();
        test_rw();
        test_rs_rc();
        test_tmask();
        test_fp_hazard();
        test_back_to_back();
        test_reset_midop();
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/csr_access_stage.md
# csr_access_stage

Front-end of the core's CSR path. It accepts CSR instructions from issue with a valid/ready handshake and performs the CSRRW/CSRRS/CSRRC read-modify-write against the CSR storage block through its read and write ports. It stalls floating-point CSR accesses while FPU operations are outstanding for that warp. Results are registered toward commit.

## Interface
- `CORE_ID`, default 0: core index, carried to assertions only.
- `NUM_WARPS`, default 4: warps per core; `NW_BITS` = max(1, clog2(NUM_WARPS)).
- `NUM_THREADS`, default 4: lanes per warp.
- `UUID_BITS`, default 44: instruction trace id width.
- `FPU_PENDING_SIZE`, default 16: maximum outstanding FPU ops per warp; counter width `PW` = clog2(FPU_PENDING_SIZE+1).
- `clk` in 1: core clock (one clock domain).
- `reset` in 1: synchronous, active-high.
- `req_valid`, `req_ready` in/out 1: issue handshake.
- `req_uuid` in UUID_BITS; `req_wid` in NW_BITS; `req_tmask` in NUM_THREADS; `req_pc` in 32; `req_rd` in 5; `req_wb` in 1.
- `req_op` in 2: 01 = RW, 10 = RS, 11 = RC; 00 is reserved.
- `req_addr` in 12: CSR address.
- `req_use_imm` in 1; `req_imm` in 5; `req_rs1` in 5; `req_rs1_data` in 32: source operand, already taken from the first active lane.
- `csr_read_enable` out 1; `csr_read_uuid` out UUID_BITS; `csr_read_addr` out 12; `csr_read_wid` out NW_BITS.
- `csr_read_data` in 32: combinational return from storage.
- `csr_write_enable` out 1; `csr_write_uuid` out UUID_BITS; `csr_write_addr` out 12; `csr_write_wid` out NW_BITS; `csr_write_data` out 32.
- `fpu_req_fire` in 1; `fpu_req_wid` in NW_BITS: an FPU op was issued.
- `fpu_rsp_fire` in 1; `fpu_rsp_wid` in NW_BITS: an FPU op completed.
- `rsp_valid`, `rsp_ready` out/in 1: commit handshake.
- `rsp_uuid`, `rsp_wid`, `rsp_tmask`, `rsp_pc`, `rsp_rd`, `rsp_wb` out: fields copied from the request.
- `rsp_data` out NUM_THREADS*32: per-lane result.
- `rsp_eop` out 1: always 1.

## Operation
- **Source value.** `src = req_use_imm ? 32'(req_imm) : req_rs1_data`.
- **Write value.** RW: `src`. RS: `old | src`. RC: `old & ~src`. Here `old = csr_read_data`.
- **Write suppression.** For RS/RC, no write occurs when the source index is zero: `req_imm==0` if `req_use_imm`, otherwise `req_rs1==0`. RW always writes.
- **Read port.**
  - `csr_read_enable = req_valid & req_ready`.
  - `csr_read_addr`, `csr_read_wid` and `csr_read_uuid` are driven from the request at all times.
- **Write port.** Asserted in the same accept cycle as the read, with `csr_write_addr = req_addr`.
- **FP-CSR hazard.**
  - Per-warp counter `pending[w]`, width PW.
  - Increments on `fpu_req_fire` for `w`; decrements on `fpu_rsp_fire` for `w`.
  - Simultaneous increment and decrement on the same warp leaves the counter unchanged.
  - Assert no overflow past FPU_PENDING_SIZE and no underflow below 0.
  - `fp_stall = (req_addr` is 0x001, 0x002 or 0x003) `& (pending[req_wid] != 0)`.
- **Accept rule.** `req_ready = ~fp_stall & (~rsp_valid | rsp_ready)`.
- **Response.**
  - On accept, the output register loads every lane of `rsp_data` with `old`, masked to zero on lanes where `req_tmask` is 0.
  - `rsp_valid` is set on accept and cleared when `rsp_ready` is seen with no new accept.
- **Reserved op.** `req_op == 00` on accept fires an assertion; the request is then treated as RS with a suppressed write.

## Timing
- Reset values:
  - all `pending` = 0, `rsp_valid` = 0, `rsp_data` = 0, `rsp_*` fields = 0;
  - `csr_write_enable` = 0, `csr_read_enable` = 0.
- **Latency.** One cycle from request accept to `rsp_valid`. The CSR write takes effect at the accept clock edge, so a back-to-back request in the next cycle reads the new value.
- **Throughput.** One request per cycle while commit is ready. A single output register means no bubble when `rsp_valid & rsp_ready`.
- **Hold rule.** While `rsp_valid & ~rsp_ready`, all `rsp_*` outputs hold stable and `req_ready` = 0.
- **Decrement visibility.** An FPU response decrementing the count to 0 in cycle N allows accept in cycle N+1, not N.
- **Increment vs. accept.** `fpu_req_fire` to warp w in the same cycle as an accepted FCSR request from w: the CSR access proceeds, because the counter was 0 when sampled.
- **Reset mid-operation.** Drops the held response and clears the counters; no CSR write is emitted in the reset cycle.

## Structure
- Shared package: CSR op encodings (RW/RS/RC) and the FP CSR addresses (FFLAGS 0x001, FRM 0x002, FCSR 0x003).
- One sub-module, `csr_fpu_pending`: a bank of per-warp up/down counters with a per-warp nonzero flag.
- The output register is inline, with no separate skid module.

## Test plan
- **RW:** CSR 0x340 holds 0x0, request RW src=0x1234 → write 0x1234 issued; rsp_data all active lanes 0x0; next read returns 0x1234.
- **RS/RC:** RS imm=5 on 0xF0 → write 0xF5, rsp 0xF0. RC rs1_data=0x0F on 0xFF → write 0xF0. RS with rs1=0 → no write, rsp returns the value.
- **FP hazard:** two fpu_req_fire on warp 1, FRM read from warp 1 → req_ready=0 until the second fpu_rsp_fire; accepted exactly one cycle later. The same access from warp 0 is accepted immediately.
- **Backpressure:** hold rsp_ready=0 for 3 cycles with req_valid high → req_ready=0, rsp fields stable; single write only; then two consecutive accepts once released.
- **tmask:** tmask=0101, CSR 0x340 value 0xAB → rsp_data lanes 0 and 2 = 0xAB, lanes 1 and 3 = 0.
- **Reset mid-op:** reset with rsp_valid=1 and pending[2]=3 → rsp_valid=0, pending cleared, a warp-2 FCSR access is accepted in the first cycle after reset.
